// File: rtl/multi_sync_stretch.sv
// Per-channel CDC synchronizer with rise/fall detect and retriggerable stretch.
// Define CDC_GLITCH_FILTER_EN to add a per-channel stability filter.
module multi_sync_stretch #(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 4,
  parameter int FILTER_CYCLES  = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_async,
  input  logic [CHANNELS-1:0] i_clr,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_stretch,
  output logic                o_any
);

  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] r_prev;
  logic [CW-1:0]       r_cnt [CHANNELS];
  logic [CHANNELS-1:0] w_sync_out;
  logic [CHANNELS-1:0] w_busy;

  // i_async feeds only the first flop of each chain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef CDC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_CYCLES - 1);

  logic [FW-1:0]       r_flt [CHANNELS];
  logic [CHANNELS-1:0] r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_flt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_sync_out[c] == r_level[c]) begin
          r_flt[c] <= '0;
        end else if (r_flt[c] == FLAST) begin
          r_level[c] <= w_sync_out[c];
          r_flt[c]   <= '0;
        end else begin
          r_flt[c] <= r_flt[c] + FW'(1);
        end
      end
    end
  end

  assign o_level = r_level;
`else
  assign o_level = w_sync_out;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= o_level;
    end
  end

  assign o_rise = o_level & ~r_prev;
  assign o_fall = ~o_level & r_prev;

  // Clear beats a same-cycle rise; a rise while busy reloads the window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_clr[c]) begin
          r_cnt[c] <= '0;
        end else if (o_rise[c]) begin
          r_cnt[c] <= LOAD;
        end else if (r_cnt[c] != '0) begin
          r_cnt[c] <= r_cnt[c] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_busy[c] = (r_cnt[c] != '0);
    end
  end

  assign o_stretch = ~i_clr & (o_rise | w_busy);
  assign o_any     = |o_stretch;

endmodule
